// File: rtl/can_pkg.sv
// Shared CAN channel definitions: bus levels, frame-tail lengths, FSM encodings.
package can_pkg;

    localparam int unsigned EOF_LEN = 7;
    localparam int unsigned INT_LEN = 3;

    localparam logic RECESSIVE = 1'b1;
    localparam logic DOMINANT  = 1'b0;

    // Frame-tail position, one-hot.
    typedef enum logic [5:0] {
        IDLE         = 6'b000001,
        ARMED        = 6'b000010,
        ACK_SLOT     = 6'b000100,
        ACK_DELIM    = 6'b001000,
        EOF          = 6'b010000,
        INTERMISSION = 6'b100000
    } tail_state_t;

    // Samples collected for the current bit, one-hot.
    typedef enum logic [3:0] {
        SMP_NONE = 4'b0001,
        SMP_ONE  = 4'b0010,
        SMP_TWO  = 4'b0100,
        SMP_DONE = 4'b1000
    } smp_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/frame_tail_gen_bit_sampler.sv
// bit_sampler: collects the samples of one bit time and produces one bit value.
// Ports: clk, reset (sync, active-high); bitStart restarts sampling; samplePulse
// marks a sample of dIn; rateSelector picks 3-sample majority (1) or first
// sample (0). bitVal/bitValid: registered bit value with a one-cycle valid.
module bit_sampler
    import can_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bitStart,
    input  logic samplePulse,
    input  logic rateSelector,
    input  logic dIn,
    output logic bitVal,
    output logic bitValid
);

    smp_state_t state, state_nxt, base;
    logic       s0, s1, s0_nxt, s1_nxt;
    logic       val_nxt, valid_nxt;

    // A sample coinciding with bitStart belongs to the new bit, so restart first.
    always_comb begin
        base      = bitStart ? SMP_NONE : state;
        state_nxt = base;
        s0_nxt    = s0;
        s1_nxt    = s1;
        val_nxt   = bitVal;
        valid_nxt = 1'b0;
        if (samplePulse) begin
            unique case (base)
                SMP_NONE: begin
                    s0_nxt = dIn;
                    if (rateSelector) begin
                        state_nxt = SMP_ONE;
                    end else begin
                        state_nxt = SMP_DONE;
                        val_nxt   = dIn;
                        valid_nxt = 1'b1;
                    end
                end
                SMP_ONE: begin
                    s1_nxt    = dIn;
                    state_nxt = SMP_TWO;
                end
                SMP_TWO: begin
                    state_nxt = SMP_DONE;
                    val_nxt   = majority3(s0, s1, dIn);
                    valid_nxt = 1'b1;
                end
                SMP_DONE: begin
                    state_nxt = SMP_DONE;
                end
                default: state_nxt = SMP_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SMP_NONE;
            s0       <= RECESSIVE;
            s1       <= RECESSIVE;
            bitVal   <= RECESSIVE;
            bitValid <= 1'b0;
        end else begin
            state    <= state_nxt;
            s0       <= s0_nxt;
            s1       <= s1_nxt;
            bitVal   <= val_nxt;
            bitValid <= valid_nxt;
        end
    end

endmodule

// File: rtl/frame_tail_gen.sv
// frame_tail_gen: drives and checks the CAN frame tail (ACK slot, ACK delimiter,
// EOF, intermission) after the CRC delimiter.
// Ports: clk, reset (sync, active-high); start arms from IDLE and latches
// ackDrive as role (1 = receiver drives ACK); bitStart/samplePulse/rateSelector
// are the shared bit-timing strobes; dIn bus receive bit. dOut bus transmit bit,
// busy (not IDLE), one-cycle status pulses ackError, formError, overload,
// sofDetect, tailDone.
module frame_tail_gen
    import can_pkg::*;
#(
    parameter int unsigned EOF_LEN = can_pkg::EOF_LEN,
    parameter int unsigned INT_LEN = can_pkg::INT_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ackDrive,
    input  logic bitStart,
    input  logic samplePulse,
    input  logic rateSelector,
    input  logic dIn,
    output logic dOut,
    output logic busy,
    output logic ackError,
    output logic formError,
    output logic overload,
    output logic sofDetect,
    output logic tailDone
);

    localparam int unsigned CNT_W = $clog2((EOF_LEN > INT_LEN) ? EOF_LEN : INT_LEN);

    tail_state_t       state, state_nxt;
    logic              role, role_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              bit_val, bit_valid;
    logic              ack_err_nxt, form_err_nxt, ovl_nxt, sof_nxt, done_nxt;
    logic              dom, eof_last, int_last;

    bit_sampler u_sampler (
        .clk          (clk),
        .reset        (reset),
        .bitStart     (bitStart),
        .samplePulse  (samplePulse),
        .rateSelector (rateSelector),
        .dIn          (dIn),
        .bitVal       (bit_val),
        .bitValid     (bit_valid)
    );

    assign dom      = bit_valid && (bit_val == DOMINANT);
    assign eof_last = (cnt == CNT_W'(EOF_LEN - 1));
    assign int_last = (cnt == CNT_W'(INT_LEN - 1));

    // Evaluation of the current bit takes priority over advancing on bitStart.
    always_comb begin
        state_nxt    = state;
        role_nxt     = role;
        cnt_nxt      = cnt;
        ack_err_nxt  = 1'b0;
        form_err_nxt = 1'b0;
        ovl_nxt      = 1'b0;
        sof_nxt      = 1'b0;
        done_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ARMED;
                    role_nxt  = ackDrive;
                    cnt_nxt   = '0;
                end
            end
            ARMED: begin
                if (bitStart) state_nxt = ACK_SLOT;
            end
            ACK_SLOT: begin
                if (bit_valid && !role && bit_val == RECESSIVE) begin
                    ack_err_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else if (bitStart) begin
                    state_nxt = ACK_DELIM;
                end
            end
            ACK_DELIM: begin
                if (dom) begin
                    form_err_nxt = 1'b1;
                    state_nxt    = IDLE;
                end else if (bitStart) begin
                    state_nxt = EOF;
                    cnt_nxt   = '0;
                end
            end
            EOF: begin
                if (dom) begin
                    // A receiver seeing dominant in the last EOF bit treats it as overload.
                    if (eof_last && role) ovl_nxt = 1'b1;
                    else                  form_err_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (bitStart) begin
                    if (eof_last) begin
                        state_nxt = INTERMISSION;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            INTERMISSION: begin
                if (bit_valid && (dom || int_last)) begin
                    if (!dom)          done_nxt = 1'b1;
                    else if (int_last) sof_nxt  = 1'b1;
                    else               ovl_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (bitStart) begin
                    if (int_last) state_nxt = IDLE;
                    else          cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            role      <= 1'b0;
            cnt       <= '0;
            dOut      <= RECESSIVE;
            busy      <= 1'b0;
            ackError  <= 1'b0;
            formError <= 1'b0;
            overload  <= 1'b0;
            sofDetect <= 1'b0;
            tailDone  <= 1'b0;
        end else begin
            state     <= state_nxt;
            role      <= role_nxt;
            cnt       <= cnt_nxt;
            dOut      <= (state_nxt == ACK_SLOT && role_nxt) ? DOMINANT : RECESSIVE;
            busy      <= (state_nxt != IDLE);
            ackError  <= ack_err_nxt;
            formError <= form_err_nxt;
            overload  <= ovl_nxt;
            sofDetect <= sof_nxt;
            tailDone  <= done_nxt;
        end
    end

endmodule

// File: doc/frame_tail_gen.md
# frame_tail_gen

Drives and supervises the CAN frame tail: ACK slot, ACK delimiter, 7-bit EOF and 3-bit intermission. It is armed once the CRC delimiter has been handled, places the ACK slot bit on the bus and checks the ACK slot bit read back from the bus. It flags ACK, form and overload conditions, and reports when the node may start a new frame. It sits beside the receive-side interframe detector in the channel unit and shares its bit-timing strobes.

## Interface
- EOF_LEN, 7, EOF bit count
- INT_LEN, 3, intermission bit count
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where reset=1
- start  in  1  one-cycle arm pulse; honoured only in IDLE, ignored otherwise
- ackDrive  in  1  role, latched with start: 1 = receiver (drive dominant ACK), 0 = transmitter (expect ACK)
- bitStart  in  1  one-cycle strobe at each bit-time boundary
- samplePulse  in  1  sample strobe within the bit (3 per bit at rateSelector=1, 1 per bit at 0)
- rateSelector  in  1  1 = 3-sample majority, 0 = single sample
- dIn  in  1  bus receive bit, 1 = recessive
- dOut  out  1  bus transmit bit, 1 = recessive
- busy  out  1  high in any state other than IDLE
- ackError  out  1  one-cycle pulse
- formError  out  1  one-cycle pulse
- overload  out  1  one-cycle pulse
- sofDetect  out  1  one-cycle pulse
- tailDone  out  1  one-cycle pulse

## Operation
- States: IDLE, ARMED, ACK_SLOT, ACK_DELIM, EOF, INTERMISSION.
- A bit counter is used in EOF (0..EOF_LEN-1) and INTERMISSION (0..INT_LEN-1).
- IDLE: start -> ARMED, ackDrive latched into role.
- ARMED: next bitStart -> ACK_SLOT.
- Each later bitStart advances one bit position: ACK_SLOT -> ACK_DELIM -> EOF bit 0..6 -> INTERMISSION bit 0..2.
- dOut: 0 only in ACK_SLOT with role=1; 1 in every other state.
- Bit evaluation uses the sampled bit value, computed once per bit:
  - rateSelector=1: majority of 3 samplePulse values of dIn.
  - rateSelector=0: the first samplePulse value.
  - The sample count restarts on every bitStart. A bit that is missing samples at the next bitStart is not evaluated.
- ACK_SLOT, role=0, sampled recessive: ackError, go to IDLE.
- ACK_SLOT, role=1: no check.
- ACK_DELIM sampled dominant: formError, IDLE.
- EOF bits 0..5 sampled dominant: formError, IDLE.
- EOF bit 6 sampled dominant:
  - role=0: formError, IDLE.
  - role=1: overload, IDLE (last EOF bit rule).
- INTERMISSION bits 0..1 sampled dominant: overload, IDLE.
- INTERMISSION bit 2 sampled dominant: sofDetect, IDLE.
- INTERMISSION bit 2 sampled recessive: tailDone, IDLE.
- At most one status pulse per frame tail. Every error or abort returns to IDLE with dOut=1.

## Timing
- Reset values:
  - state IDLE, dOut=1, busy=0, all pulses 0.
  - Sample count 0, bit counter 0, role 0.
- dOut and state are registered and change on the clk edge after bitStart is sampled high.
- start and bitStart high in the same cycle while in IDLE: only enter ARMED. ACK_SLOT is entered on the next bitStart.
- The sampled bit value is registered on the edge after the completing samplePulse. Status pulses assert the following cycle, so their latency is 2 clk after that samplePulse.
- bitStart and samplePulse high in the same cycle: the sample is counted for the new bit.
- Reset mid-tail: IDLE with dOut=1 on that same edge. No pulse is emitted.
- busy drops in the same cycle that a terminal pulse is high.

## Structure
- Shared package can_pkg holds:
  - tail_state_t enum.
  - EOF_LEN and INT_LEN default constants.
  - RECESSIVE=1'b1 and DOMINANT=1'b0.
- Sub-module bit_sampler: sample counter and majority vote. Inputs: bitStart, samplePulse, rateSelector, dIn. Outputs: bitVal, bitValid.
- Both state machines use one-hot encoding.

## Test plan
- Transmitter happy path: ackDrive=0, rateSelector=1, dIn dominant only in ACK slot -> no errors, tailDone exactly 2 clk after the last sample of intermission bit 2, busy 0 afterwards.
- Missing ACK: ackDrive=0, ACK slot samples 1,1,0 (majority recessive) -> ackError and IDLE; dOut stays 1 throughout.
- Receiver ACK: ackDrive=1, rateSelector=0 -> dOut=0 for exactly the ACK_SLOT bit time. Dominant dIn at EOF bit 6 -> overload, no formError.
- Form errors: dominant at ACK_DELIM -> formError. Separate run, dominant at EOF bit 3 -> formError. Both return to IDLE.
- Intermission: dominant at bit 1 -> overload. Dominant at bit 2 -> sofDetect. Samples 0,1,1 at bit 2 -> tailDone.
- Reset at EOF bit 4 -> next cycle IDLE, dOut=1, no pulses. start then gives a clean full tail.
